// File: rtl/demixer.sv
// demixer: turns N real samples per beat into N complex I/Q samples and
// downconverts them by 0, fs/2 or fs/4, with a 2-stage AXI4-Stream pipeline.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   s_axis_*           real input stream, lane n at [B*n +: B], lane 0 oldest
//   m_axis_*           complex output stream, lane n: I at [2B*n +: B],
//                      Q at [2B*n+B +: B]
//   MODE_REG           0 bypass, 1 fs/2, 2 fs/4, 3 treated as bypass;
//                      sampled on the first beat of each packet
module demixer #(
    parameter int N = 16,
    parameter int B = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N*B-1:0]   s_axis_tdata,
    input  logic             s_axis_tvalid,
    input  logic             s_axis_tlast,
    output logic             s_axis_tready,
    output logic [2*N*B-1:0] m_axis_tdata,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    input  logic             m_axis_tready,
    input  logic [1:0]       MODE_REG
);

    logic             rdy_en;
    logic             v1;
    logic             v2;
    logic [N*B-1:0]   d1;
    logic             l1;
    logic [1:0]       m1;
    logic [1:0]       mode_q;
    logic             pkt_start;
    logic [2*N*B-1:0] d2;
    logic             l2;
    logic             ld2;
    logic             acc;
    logic [1:0]       mode_use;
    logic [2*N*B-1:0] mixed;

    function automatic logic [B-1:0] neg_sat(input logic [B-1:0] v);
        logic [B-1:0] r;
        if (v == {1'b1, {(B-1){1'b0}}}) begin
            r = {1'b0, {(B-1){1'b1}}};
        end else begin
            r = -v;
        end
        return r;
    endfunction

    // Stage 2 can take a beat when empty or when its beat leaves this cycle;
    // stage 1 can then always take one when it is empty or moving.
    assign ld2           = !v2 || m_axis_tready;
    assign s_axis_tready = rdy_en && (!v1 || !v2 || m_axis_tready);
    assign acc           = s_axis_tvalid && s_axis_tready;

    // First beat of a packet uses the live MODE_REG, the rest the latched one.
    assign mode_use = pkt_start ? MODE_REG : mode_q;

    // Input is held off for one cycle after reset release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_q    <= 2'd0;
            pkt_start <= 1'b1;
        end else if (acc) begin
            if (pkt_start) begin
                mode_q <= MODE_REG;
            end
            pkt_start <= s_axis_tlast;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1 <= 1'b0;
            d1 <= '0;
            l1 <= 1'b0;
            m1 <= 2'd0;
        end else if (s_axis_tready) begin
            v1 <= s_axis_tvalid;
            if (s_axis_tvalid) begin
                d1 <= s_axis_tdata;
                l1 <= s_axis_tlast;
                m1 <= mode_use;
            end
        end
    end

    always_comb begin
        logic [B-1:0] x;
        logic [B-1:0] nx;
        logic [B-1:0] ival;
        logic [B-1:0] qval;
        mixed = '0;
        x     = '0;
        nx    = '0;
        ival  = '0;
        qval  = '0;
        for (int n = 0; n < N; n++) begin
            x    = d1[B*n +: B];
            nx   = neg_sat(x);
            ival = x;
            qval = '0;
            case (m1)
                2'd1: begin
                    if (n % 2 == 1) ival = nx;
                end
                2'd2: begin
                    case (n % 4)
                        1: begin ival = '0; qval = nx; end
                        2: begin ival = nx; end
                        3: begin ival = '0; qval = x;  end
                        default: ;
                    endcase
                end
                default: ;
            endcase
            mixed[2*B*n +: B]     = ival;
            mixed[2*B*n + B +: B] = qval;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v2 <= 1'b0;
            d2 <= '0;
            l2 <= 1'b0;
        end else if (ld2) begin
            v2 <= v1;
            if (v1) begin
                d2 <= mixed;
                l2 <= l1;
            end
        end
    end

    assign m_axis_tvalid = v2;
    assign m_axis_tdata  = d2;
    assign m_axis_tlast  = l2;

endmodule
